// File: rtl/eth_header_builder.sv
// Ethernet II header serializer: latches MACs, optional 802.1Q tag and EtherType on start,
// then streams the header one byte per valid/ready handshake.
package eth_header_pkg;
    typedef logic [15:0] ethertype_t;
endpackage

module eth_header_builder
    import eth_header_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [1:0]  proto_sel,
    input  ethertype_t  raw_ethertype,
    input  logic        vlan_en,
    input  logic [15:0] vlan_tci,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_first,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic [4:0]  hdr_len
);

    typedef enum logic [2:0] {IDLE, DST, SRC, VLAN, ETYPE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] tci_q, tci_d;
    ethertype_t  etype_q, etype_d;
    logic        vlan_q, vlan_d;
    logic [4:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        hs;
    logic [2:0]  last_idx;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

    // A byte moves only on a cycle where out_valid and out_ready are both high; while
    // out_ready is low the state and counter hold, so out_data/out_first/out_last stay put.
    assign hs = out_valid & out_ready;

    always_comb begin
        last_idx = 3'd5;
        case (state_q)
            VLAN:    last_idx = 3'd3;
            ETYPE:   last_idx = 3'd1;
            default: last_idx = 3'd5;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        src_d   = src_q;
        tci_d   = tci_q;
        etype_d = etype_q;
        vlan_d  = vlan_q;
        len_d   = len_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = DST;
                cnt_d   = 3'd0;
                dst_d   = dst_mac;
                src_d   = src_mac;
                tci_d   = vlan_tci;
                vlan_d  = vlan_en;
                len_d   = vlan_en ? 5'd18 : 5'd14;
                case (proto_sel)
                    2'b00:   etype_d = 16'h0800;
                    2'b01:   etype_d = 16'h86DD;
                    2'b10:   etype_d = 16'h0806;
                    default: etype_d = raw_ethertype;
                endcase
            end
        end else if (hs) begin
            if (cnt_q == last_idx) begin
                cnt_d = 3'd0;
                case (state_q)
                    DST:     state_d = SRC;
                    SRC:     state_d = vlan_q ? VLAN : ETYPE;
                    VLAN:    state_d = ETYPE;
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            dst_q   <= 48'd0;
            src_q   <= 48'd0;
            tci_q   <= 16'd0;
            etype_q <= 16'd0;
            vlan_q  <= 1'b0;
            len_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            tci_q   <= tci_d;
            etype_q <= etype_d;
            vlan_q  <= vlan_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode straight from the registered state, so IDLE (and hence reset) yields zeros.
    always_comb begin
        out_data = 8'h00;
        case (state_q)
            DST:  out_data = mac_byte(dst_q, cnt_q);
            SRC:  out_data = mac_byte(src_q, cnt_q);
            VLAN: begin
                case (cnt_q)
                    3'd0:    out_data = 8'h81;
                    3'd1:    out_data = 8'h00;
                    3'd2:    out_data = tci_q[15:8];
                    default: out_data = tci_q[7:0];
                endcase
            end
            ETYPE: out_data = (cnt_q == 3'd0) ? etype_q[15:8] : etype_q[7:0];
            default: out_data = 8'h00;
        endcase
    end

    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign out_first = (state_q == DST) && (cnt_q == 3'd0);
    assign out_last  = (state_q == ETYPE) && (cnt_q == 3'd1);
    assign done      = done_q;
    assign hdr_len   = len_q;

endmodule

// File: doc/eth_header_builder.md
ETH_HEADER_BUILDER -- requirements
Module: eth_header_builder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to build one header; sampled only in IDLE.
REQ-004 SHALL have port dst_mac, input, 48, destination MAC; bits [47:40] are sent first.
REQ-005 SHALL have port src_mac, input, 48, source MAC; bits [47:40] are sent first.
REQ-006 SHALL have port proto_sel, input, 2, payload protocol: 00 IPv4, 01 IPv6, 10 ARP, 11 raw.
REQ-007 SHALL have port raw_ethertype, input, ethertype_t (16), EtherType used when proto_sel=11.
REQ-008 SHALL have port vlan_en, input, 1, insert an 802.1Q tag.
REQ-009 SHALL have port vlan_tci, input, 16, tag control field (PCP/DEI/VID).
REQ-010 SHALL have port out_data, output, 8, header byte.
REQ-011 SHALL have port out_valid, output, 1, out_data is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the byte.
REQ-013 SHALL have port out_first, output, 1, marks byte 0 of the header.
REQ-014 SHALL have port out_last, output, 1, marks the final header byte.
REQ-015 SHALL have port busy, output, 1, a header is in progress.
REQ-016 SHALL have port done, output, 1, single-cycle pulse after the final byte is accepted.
REQ-017 SHALL have port hdr_len, output, 5, length of the latched header: 14 or 18.

Function
REQ-018 SHALL implement FSM states IDLE, DST, SRC, VLAN, ETYPE with a byte-index counter inside each state.
REQ-019 SHALL, in IDLE with start=1, latch all header inputs and enter DST, with busy=1 and out_valid=1 on the next cycle (1-cycle latency).
REQ-020 SHALL ignore start while busy=1; latched fields stay stable for the whole frame regardless of input changes.
REQ-021 SHALL register each byte transfer (handshake) only when out_valid and out_ready are both 1; out_data, out_first and out_last SHALL hold steady while out_valid=1 and out_ready=0.
REQ-022 SHALL emit the bytes in this order: 6 bytes dst_mac, 6 bytes src_mac, then {8'h81, 8'h00, tci[15:8], tci[7:0]} if vlan_en, then the EtherType high byte followed by its low byte.
REQ-023 SHALL map the EtherType as: 00 to 16'h0800, 01 to 16'h86DD, 10 to 16'h0806, 11 to raw_ethertype.
REQ-024 SHALL set hdr_len, latched at start, to 18 when vlan_en=1 and to 14 otherwise; hdr_len SHALL hold its value until the next accepted start.
REQ-025 SHALL transition DST to SRC after the 6th handshake, SRC to VLAN (if vlan_en) or ETYPE after the 6th, VLAN to ETYPE after the 4th, and ETYPE to IDLE after the 2nd.
REQ-026 SHALL assert out_first only on dst byte 0 and out_last only on the EtherType low byte.
REQ-027 SHALL, on the out_last handshake, deassert out_valid and busy on the next cycle and pulse done=1 for exactly that one cycle.
REQ-028 SHALL accept a start that arrives in the same cycle as done, so that headers can run back to back with one idle cycle between frames.
REQ-029 SHALL never produce more than hdr_len handshakes per start; the byte counter SHALL NOT wrap within a frame.

Reset
REQ-030 SHALL, while rst=1, force the FSM to IDLE and clear out_data, out_valid, out_first, out_last, busy, done, hdr_len and the counter to 0, asynchronously.
REQ-031 SHALL, when rst is asserted mid-frame, abandon the frame with no done pulse; after rst deasserts, no byte is emitted until a new start.

Verification
REQ-032 SHALL be verified by: start with dst=FF:FF:FF:FF:FF:FF, src=00:11:22:33:44:55, proto_sel=00, vlan_en=0, out_ready=1 -> 14 bytes ending 08 00, first/last on bytes 0/13, hdr_len=14, done one cycle after byte 13.
REQ-033 SHALL be verified by: proto_sel=01, vlan_en=1, tci=16'h6064 -> bytes 12..17 = 81 00 60 64 86 DD, hdr_len=18.
REQ-034 SHALL be verified by: proto_sel=11, raw_ethertype=16'h88CC, with out_ready toggling 1/0 every cycle -> all 14 bytes delivered in order with no duplicates or drops, and out_data stable during each stall.
REQ-035 SHALL be verified by: a second start pulsed during busy -> ignored; then start asserted in the done cycle -> new frame out_first occurs 1 cycle later.
REQ-036 SHALL be verified by: rst asserted after byte 7 -> all outputs 0 immediately and no done; a fresh ARP start then emits 14 bytes ending 08 06.
